// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: control codes,
// register address width and sequencer state encodings.
package pipeline_hazard_ctrl_pkg;

   // Hazard-control code applied to each pipeline stage register
   localparam int HAZD_CTL_WIDTH = 2;

   localparam logic [HAZD_CTL_WIDTH-1:0] HAZD_CTL_NORMAL = 2'd0;  // load new contents
   localparam logic [HAZD_CTL_WIDTH-1:0] HAZD_CTL_RETRY  = 2'd1;  // hold current contents
   localparam logic [HAZD_CTL_WIDTH-1:0] HAZD_CTL_NO_OP  = 2'd2;  // insert a bubble

   // Register-file address width
   localparam int HAZD_REG_ADDR_WIDTH = 5;

   // Sequencer states
   typedef enum logic [1:0] {
      CTL_ST_RUN      = 2'd0,
      CTL_ST_MEM_WAIT = 2'd1,
      CTL_ST_HALT     = 2'd2
   } ctl_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard detection: the instruction in ID reads a register that the
// load currently in EX has not produced yet. Register 0 never creates a hazard.
module pipeline_hazard_ctrl_load_use_detect
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = HAZD_REG_ADDR_WIDTH
) (
   input  logic [REG_ADDR_WIDTH-1:0] id_rs,
   input  logic [REG_ADDR_WIDTH-1:0] id_rt,
   input  logic                      id_uses_rs,
   input  logic                      id_uses_rt,
   input  logic                      ex_mem_read,
   input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
   output logic                      load_use
);

   logic rd_nonzero;
   logic rs_match;
   logic rt_match;

   // Compare the ID source fields against the EX load destination
   always_comb begin
      rd_nonzero = (ex_rd != '0);
      rs_match   = id_uses_rs && (id_rs == ex_rd);
      rt_match   = id_uses_rt && (id_rt == ex_rd);
      load_use   = ex_mem_read && rd_nonzero && (rs_match || rt_match);
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard sequencer for the 5-stage pipeline. Produces per-stage
// control codes and the PC hold for load-use stalls, multi-cycle memory waits
// (with timeout) and externally requested halts, and counts stall cycles.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int CTL_WIDTH      = HAZD_CTL_WIDTH,
   parameter int REG_ADDR_WIDTH = HAZD_REG_ADDR_WIDTH,
   parameter int MEM_TIMEOUT    = 256,
   parameter int DRAIN_CYCLES   = 4,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs,
   input  logic [REG_ADDR_WIDTH-1:0] id_rt,
   input  logic                      id_uses_rs,
   input  logic                      id_uses_rt,
   input  logic                      ex_mem_read,
   input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
   input  logic                      mem_req,
   input  logic                      mem_ready,
   input  logic                      halt_req,
   input  logic                      clear_err,
   output logic [CTL_WIDTH-1:0]      if_ctl,
   output logic [CTL_WIDTH-1:0]      id_ctl,
   output logic [CTL_WIDTH-1:0]      ex_ctl,
   output logic [CTL_WIDTH-1:0]      mem_ctl,
   output logic [CTL_WIDTH-1:0]      wb_ctl,
   output logic                      pc_hold,
   output logic                      ignore_no_op,
   output logic                      halted,
   output logic                      mem_timeout,
   output logic [CNT_WIDTH-1:0]      stall_count
);

   localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
   localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

   localparam logic [WAIT_W-1:0]    WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
   localparam logic [DRAIN_W-1:0]   DRAIN_MAX = DRAIN_W'(DRAIN_CYCLES);
   localparam logic [CTL_WIDTH-1:0] C_NORMAL  = CTL_WIDTH'(HAZD_CTL_NORMAL);
   localparam logic [CTL_WIDTH-1:0] C_RETRY   = CTL_WIDTH'(HAZD_CTL_RETRY);
   localparam logic [CTL_WIDTH-1:0] C_NO_OP   = CTL_WIDTH'(HAZD_CTL_NO_OP);

   // Registered state
   ctl_state_e           state_q,       state_d;
   logic [WAIT_W-1:0]    wait_cnt_q,    wait_cnt_d;
   logic [DRAIN_W-1:0]   drain_cnt_q,   drain_cnt_d;
   logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
   logic                 mem_timeout_q, mem_timeout_d;

   // Un-gated decisions for the current cycle
   logic                 load_use;
   logic [CTL_WIDTH-1:0] if_c, id_c, ex_c, mem_c, wb_c;
   logic                 pc_hold_c;
   logic                 ignore_c;
   logic                 halted_c;
   logic                 count_stall;
   logic                 set_timeout;

   pipeline_hazard_ctrl_load_use_detect #(
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
   ) u_load_use_detect (
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rs  (id_uses_rs),
      .id_uses_rt  (id_uses_rt),
      .ex_mem_read (ex_mem_read),
      .ex_rd       (ex_rd),
      .load_use    (load_use)
   );

   // Sequencer: per-stage codes, PC hold and next state from state and inputs
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      drain_cnt_d = drain_cnt_q;
      if_c        = C_NORMAL;
      id_c        = C_NORMAL;
      ex_c        = C_NORMAL;
      mem_c       = C_NORMAL;
      wb_c        = C_NORMAL;
      pc_hold_c   = 1'b0;
      ignore_c    = 1'b0;
      halted_c    = 1'b0;
      count_stall = 1'b0;
      set_timeout = 1'b0;

      unique case (state_q)
         CTL_ST_RUN: begin
            if (mem_req && !mem_ready) begin
               // Freeze everything up to MEM; WB receives a bubble
               if_c        = C_RETRY;
               id_c        = C_RETRY;
               ex_c        = C_RETRY;
               mem_c       = C_RETRY;
               wb_c        = C_NO_OP;
               pc_hold_c   = 1'b1;
               count_stall = 1'b1;
               state_d     = CTL_ST_MEM_WAIT;
               wait_cnt_d  = WAIT_W'(1);
            end else if (halt_req) begin
               // Stop fetching and let the in-flight instructions drain
               if_c        = C_NO_OP;
               pc_hold_c   = 1'b1;
               state_d     = CTL_ST_HALT;
               drain_cnt_d = DRAIN_W'(1);
            end else if (load_use) begin
               // Hold IF/ID one cycle and send a bubble into EX
               if_c        = C_RETRY;
               id_c        = C_RETRY;
               ex_c        = C_NO_OP;
               pc_hold_c   = 1'b1;
               count_stall = 1'b1;
            end
         end

         CTL_ST_MEM_WAIT: begin
            if (mem_ready) begin
               // Access completed: resume, and IF/ID must not take the stale no-op flag
               ignore_c   = 1'b1;
               state_d    = CTL_ST_RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q < WAIT_MAX) begin
               if_c        = C_RETRY;
               id_c        = C_RETRY;
               ex_c        = C_RETRY;
               mem_c       = C_RETRY;
               wb_c        = C_NO_OP;
               pc_hold_c   = 1'b1;
               count_stall = 1'b1;
               wait_cnt_d  = wait_cnt_q + WAIT_W'(1);
            end else begin
               // Abandon the access: MEM result is dropped by bubbling WB
               wb_c        = C_NO_OP;
               ignore_c    = 1'b1;
               count_stall = 1'b1;
               set_timeout = 1'b1;
               state_d     = CTL_ST_RUN;
               wait_cnt_d  = '0;
            end
         end

         CTL_ST_HALT: begin
            if_c      = C_NO_OP;
            pc_hold_c = 1'b1;
            halted_c  = (drain_cnt_q == DRAIN_MAX);
            if (!halt_req) begin
               state_d     = CTL_ST_RUN;
               drain_cnt_d = '0;
            end else if (drain_cnt_q < DRAIN_MAX) begin
               drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
            end
         end

         default: begin
            state_d     = CTL_ST_RUN;
            wait_cnt_d  = '0;
            drain_cnt_d = '0;
         end
      endcase
   end

   // Saturating stall counter and sticky timeout flag (set beats clear)
   always_comb begin
      stall_count_d = stall_count_q;
      if (count_stall && (stall_count_q != '1)) begin
         stall_count_d = stall_count_q + CNT_WIDTH'(1);
      end
      mem_timeout_d = mem_timeout_q;
      if (set_timeout) begin
         mem_timeout_d = 1'b1;
      end else if (clear_err) begin
         mem_timeout_d = 1'b0;
      end
   end

   // State and counter registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= CTL_ST_RUN;
         wait_cnt_q    <= '0;
         drain_cnt_q   <= '0;
         stall_count_q <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         drain_cnt_q   <= drain_cnt_d;
         stall_count_q <= stall_count_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   // While reset is held every stage gets a bubble and the PC is frozen
   always_comb begin
      if (!rst_n) begin
         if_ctl       = C_NO_OP;
         id_ctl       = C_NO_OP;
         ex_ctl       = C_NO_OP;
         mem_ctl      = C_NO_OP;
         wb_ctl       = C_NO_OP;
         pc_hold      = 1'b1;
         ignore_no_op = 1'b0;
         halted       = 1'b0;
      end else begin
         if_ctl       = if_c;
         id_ctl       = id_c;
         ex_ctl       = ex_c;
         mem_ctl      = mem_c;
         wb_ctl       = wb_c;
         pc_hold      = pc_hold_c;
         ignore_no_op = ignore_c;
         halted       = halted_c;
      end
   end

   assign stall_count = stall_count_q;
   assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

   localparam int RW   = 5;
   localparam int TMO  = 8;
   localparam int DRN  = 4;
   localparam int CW   = 6;
   localparam longint CMAX = (64'd1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [RW-1:0] id_rs = '0, id_rt = '0, ex_rd = '0;
   logic          id_uses_rs = 1'b0, id_uses_rt = 1'b0, ex_mem_read = 1'b0;
   logic          mem_req = 1'b0, mem_ready = 1'b0, halt_req = 1'b0, clear_err = 1'b0;
   logic [1:0]    if_ctl, id_ctl, ex_ctl, mem_ctl, wb_ctl;
   logic          pc_hold, ignore_no_op, halted, mem_timeout;
   logic [CW-1:0] stall_count;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(
      .CTL_WIDTH      (2),
      .REG_ADDR_WIDTH (RW),
      .MEM_TIMEOUT    (TMO),
      .DRAIN_CYCLES   (DRN),
      .CNT_WIDTH      (CW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_uses_rs   (id_uses_rs),
      .id_uses_rt   (id_uses_rt),
      .ex_mem_read  (ex_mem_read),
      .ex_rd        (ex_rd),
      .mem_req      (mem_req),
      .mem_ready    (mem_ready),
      .halt_req     (halt_req),
      .clear_err    (clear_err),
      .if_ctl       (if_ctl),
      .id_ctl       (id_ctl),
      .ex_ctl       (ex_ctl),
      .mem_ctl      (mem_ctl),
      .wb_ctl       (wb_ctl),
      .pc_hold      (pc_hold),
      .ignore_no_op (ignore_no_op),
      .halted       (halted),
      .mem_timeout  (mem_timeout),
      .stall_count  (stall_count)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mode: "run", "wait", "halt"; waited = stall cycles spent on the current
   // access (entry included); drained = cycles since fetch stopped.
   string  m_mode = "run";
   int     m_waited = 0, m_drained = 0;
   longint m_cnt = 0;
   bit     m_to = 1'b0;
   // next values
   string  n_mode;
   int     n_waited, n_drained;
   longint n_cnt;
   bit     n_to;
   // expected outputs: stage codes listed IF..WB
   int     e_code[5];
   bit     e_pc, e_ign, e_halted;

   function automatic void set_codes(input int a, input int b, input int c, input int d, input int e);
      e_code[0] = a; e_code[1] = b; e_code[2] = c; e_code[3] = d; e_code[4] = e;
   endfunction

   task automatic model_eval();
      bit hazard, stalled, to_set;
      if (!rst_n) begin
         m_mode = "run"; m_waited = 0; m_drained = 0; m_cnt = 0; m_to = 0;
      end
      n_mode = m_mode; n_waited = m_waited; n_drained = m_drained;
      stalled = 0; to_set = 0;
      set_codes(0, 0, 0, 0, 0);
      e_pc = 0; e_ign = 0; e_halted = 0;
      hazard = ex_mem_read && (ex_rd != 0) &&
               ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
      if (!rst_n) begin
         set_codes(2, 2, 2, 2, 2);
         e_pc = 1;
      end else if (m_mode == "run") begin
         if (mem_req && !mem_ready) begin
            set_codes(1, 1, 1, 1, 2); e_pc = 1; stalled = 1;
            n_mode = "wait"; n_waited = 1;
         end else if (halt_req) begin
            set_codes(2, 0, 0, 0, 0); e_pc = 1;
            n_mode = "halt"; n_drained = 1;
         end else if (hazard) begin
            set_codes(1, 1, 2, 0, 0); e_pc = 1; stalled = 1;
         end
      end else if (m_mode == "wait") begin
         if (mem_ready) begin
            e_ign = 1; n_mode = "run"; n_waited = 0;
         end else if (m_waited < TMO) begin
            set_codes(1, 1, 1, 1, 2); e_pc = 1; stalled = 1;
            n_waited = m_waited + 1;
         end else begin
            set_codes(0, 0, 0, 0, 2); e_ign = 1; stalled = 1; to_set = 1;
            n_mode = "run"; n_waited = 0;
         end
      end else begin
         set_codes(2, 0, 0, 0, 0); e_pc = 1;
         e_halted = (m_drained == DRN);
         if (!halt_req) begin
            n_mode = "run"; n_drained = 0;
         end else if (m_drained < DRN) begin
            n_drained = m_drained + 1;
         end
      end
      n_cnt = (stalled && m_cnt < CMAX) ? m_cnt + 1 : m_cnt;
      n_to  = to_set ? 1'b1 : (clear_err ? 1'b0 : m_to);
      if (!rst_n) begin
         n_cnt = 0; n_to = 0;
      end
   endtask

   // One clock: inputs already driven; check at the falling edge, advance at rise.
   task automatic step();
      logic [9:0] exp_codes;
      @(negedge clk);
      model_eval();
      exp_codes = {e_code[0][1:0], e_code[1][1:0], e_code[2][1:0], e_code[3][1:0], e_code[4][1:0]};
      check_eq("stage_codes", {54'd0, if_ctl, id_ctl, ex_ctl, mem_ctl, wb_ctl}, {54'd0, exp_codes});
      check_eq("pc_hold",     {63'd0, pc_hold},      {63'd0, e_pc});
      check_eq("ignore_no_op",{63'd0, ignore_no_op}, {63'd0, e_ign});
      check_eq("halted",      {63'd0, halted},       {63'd0, e_halted});
      check_eq("mem_timeout", {63'd0, mem_timeout},  {63'd0, m_to});
      check_eq("stall_count", {58'd0, stall_count},  m_cnt);
      @(posedge clk);
      #1;
      cyc++;
      m_mode = n_mode; m_waited = n_waited; m_drained = n_drained;
      m_cnt = n_cnt; m_to = n_to;
   endtask

   task automatic idle_inputs();
      id_rs = '0; id_rt = '0; ex_rd = '0;
      id_uses_rs = 0; id_uses_rt = 0; ex_mem_read = 0;
      mem_req = 0; mem_ready = 0; halt_req = 0; clear_err = 0;
   endtask

   task automatic set_load_use(input int rd, input bit rd_load, input bit uses);
      ex_rd = RW'(rd); ex_mem_read = rd_load; id_rs = 5'd5; id_uses_rs = uses;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int ready_div;
      idle_inputs();
      rst_n = 0;
      step(); step();
      rst_n = 1;
      step();

      // load-use stall, then cleared
      set_load_use(5, 1, 1); step();
      ex_mem_read = 0; step();
      set_load_use(0, 1, 1); id_rs = 5'd0; step();
      set_load_use(5, 1, 0); step();
      set_load_use(3, 1, 0); id_rt = 5'd3; id_uses_rt = 1; step();
      idle_inputs(); step();

      // memory wait of 3 cycles, then release
      mem_req = 1; mem_ready = 0;
      repeat (3) step();
      mem_ready = 1; step();
      idle_inputs(); step();

      // timeout: 8 stall cycles, then abandon; clear afterwards
      mem_req = 1; mem_ready = 0;
      repeat (TMO + 1) step();
      idle_inputs(); step();
      clear_err = 1; step();
      clear_err = 0; step();

      // timeout coinciding with ready: ready wins
      mem_req = 1; mem_ready = 0;
      repeat (TMO) step();
      mem_ready = 1; step();
      idle_inputs(); step();

      // halt drain and exit
      halt_req = 1;
      repeat (DRN + 3) step();
      halt_req = 0; step();
      step();
      // early halt exit
      halt_req = 1; repeat (2) step();
      halt_req = 0; step(); step();

      // reset in the middle of a memory wait and of a halt
      mem_req = 1; mem_ready = 0; repeat (3) step();
      rst_n = 0; step(); step();
      rst_n = 1; idle_inputs(); step();
      halt_req = 1; repeat (3) step();
      rst_n = 0; step();
      rst_n = 1; halt_req = 0; step();

      // halt and load-use together: halt wins
      set_load_use(5, 1, 1); halt_req = 1; step();
      halt_req = 0; ex_mem_read = 0; step(); step();

      // saturation of the stall counter
      set_load_use(7, 1, 1); id_rs = 5'd7;
      repeat (int'(CMAX) + 6) step();
      check_eq("stall_count_saturated", {58'd0, stall_count}, CMAX);
      idle_inputs(); step();

      // randomized traffic
      ready_div = 3;
      for (int i = 0; i < 4000; i++) begin
         if (i % 250 == 0) ready_div = (i / 250) % 3 == 0 ? 2 : ((i / 250) % 3 == 1 ? 6 : 25);
         id_rs       = RW'($urandom_range(0, 3));
         id_rt       = RW'($urandom_range(0, 3));
         ex_rd       = RW'($urandom_range(0, 3));
         id_uses_rs  = $urandom_range(0, 1) == 1;
         id_uses_rt  = $urandom_range(0, 1) == 1;
         ex_mem_read = $urandom_range(0, 2) == 0;
         mem_req     = $urandom_range(0, 3) == 0;
         mem_ready   = ($urandom % ready_div) == 0;
         clear_err   = $urandom_range(0, 15) == 0;
         if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
         rst_n       = $urandom_range(0, 499) != 0;
         step();
      end
      rst_n = 1;
      idle_inputs(); step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
